// File: rtl/ser_frame_router.sv
// rtl/ser_frame_router.sv - serial frame receiver that routes data bits to addressed channels
//
// Receives frames of the form: start(0), address (ADDR_W, MSB first),
// length (LEN_W, MSB first), L data bits, optional even-parity bit.
// Data bits are forwarded to the addressed channel while it is valid.
//
// Ports:
//   clk          in   rising-edge system clock
//   rst          in   asynchronous reset, active-low
//   clkEn        in   bit strobe; serIn sampled only on enabled edges
//   serIn        in   serial line, idles high
//   serOut       out  per-channel routed data (serIn gated by channel valid)
//   serOutValid  out  one-hot channel valid during DATA
//   count_out    out  data bits remaining (current included), 0 outside DATA
//   busy         out  high whenever not IDLE
//   frameDone    out  one-clk pulse after the last bit of a frame
//   parityErr    out  one-clk pulse with frameDone on parity mismatch
module ser_frame_router #(
  parameter int ADDR_W    = 2,
  parameter int LEN_W     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clkEn,
  input  logic                     serIn,
  output logic [(1<<ADDR_W)-1:0]   serOut,
  output logic [(1<<ADDR_W)-1:0]   serOutValid,
  output logic [LEN_W-1:0]         count_out,
  output logic                     busy,
  output logic                     frameDone,
  output logic                     parityErr
);

  localparam int N  = 1 << ADDR_W;
  localparam int FW = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
  localparam int CW = $clog2(FW + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_PAR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              par_q, par_d;
  logic              frame_done_q, frame_done_d;
  logic              parity_err_q, parity_err_d;
  logic [LEN_W-1:0]  len_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      count_q      <= '0;
      bit_cnt_q    <= '0;
      par_q        <= 1'b0;
      frame_done_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      bit_cnt_q    <= bit_cnt_d;
      par_q        <= par_d;
      frame_done_q <= frame_done_d;
      parity_err_q <= parity_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    count_d      = count_q;
    bit_cnt_d    = bit_cnt_q;
    par_d        = par_q;
    // Pulses are not held by clkEn: they clear on the very next clk edge.
    frame_done_d = 1'b0;
    parity_err_d = 1'b0;
    // The length field is assembled in count_q; len_next is the full value
    // once the final length bit is shifted in.
    len_next     = LEN_W'({count_q, serIn});

    if (clkEn) begin
      case (state_q)
        S_IDLE: begin
          if (!serIn) begin
            state_d   = S_ADDR;
            bit_cnt_d = '0;
            par_d     = 1'b0;
          end
        end
        S_ADDR: begin
          addr_d = ADDR_W'({addr_q, serIn});
          if (bit_cnt_q == CW'(ADDR_W - 1)) begin
            state_d   = S_LEN;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
        S_LEN: begin
          count_d = len_next;
          if (bit_cnt_q == CW'(LEN_W - 1)) begin
            bit_cnt_d = '0;
            if (len_next != '0) begin
              state_d = S_DATA;
            end else if (PARITY_EN != 0) begin
              state_d = S_PAR;
            end else begin
              state_d      = S_IDLE;
              frame_done_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          par_d   = par_q ^ serIn;
          count_d = count_q - LEN_W'(1);
          // Exit at 1 so the counter never wraps through zero.
          if (count_q == LEN_W'(1)) begin
            if (PARITY_EN != 0) begin
              state_d = S_PAR;
            end else begin
              state_d      = S_IDLE;
              frame_done_d = 1'b1;
            end
          end
        end
        S_PAR: begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
          parity_err_d = (serIn != par_q);
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign serOutValid = (state_q == S_DATA) ? (N'(1) << addr_q) : '0;
  assign serOut      = serOutValid & {N{serIn}};
  assign count_out   = (state_q == S_DATA) ? count_q : '0;
  assign busy        = (state_q != S_IDLE);
  assign frameDone   = frame_done_q;
  assign parityErr   = parity_err_q;

endmodule
